branch_operand_hazard_unit: RTL and testbench

- ID-stage hazard and forwarding unit for early branch resolution. Generalises EX→ID branch forwarding to N branch source operands.
- Adds MEM→ID forwarding, $zero suppression, EX-over-MEM priority, and a sequential load-use stall FSM with a down-counter.
- Sits beside the ID-stage comparator: drives per-operand bypass mux selects plus the pipeline stall/bubble controls for PC, IF/ID and ID/EX.

---
 rtl/branch_operand_hazard_unit_pkg.sv | 16 +
 rtl/branch_operand_hazard_unit_operand_fwd_match.sv | 42 ++++
 rtl/branch_operand_hazard_unit.sv | 123 ++++++++++++
 tb/tb_branch_operand_hazard_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_operand_hazard_unit_pkg.sv
// Shared definitions for the ID-stage branch operand hazard/forwarding unit:
// bypass select encodings, FSM state type and default register width.
package branch_operand_hazard_unit_pkg;

    localparam int unsigned DEFAULT_REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/branch_operand_hazard_unit_operand_fwd_match.sv
// Per-operand producer match: bypass select plus load-hazard flags for one
// branch source register. $zero never matches; EX wins over MEM.
module operand_fwd_match
    import branch_operand_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic [1:0]            sel,
    output logic                  haz_ex,
    output logic                  haz_mem
);

    logic match_ex;
    logic match_mem;
    logic fwd_ex;

    assign match_ex  = enable && ex_reg_write && (ex_rd != '0) && (ex_rd == src);
    assign match_mem = enable && mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    assign fwd_ex    = match_ex && !ex_mem_read;

    assign haz_ex  = match_ex && ex_mem_read;
    // A younger non-load writer in EX shadows any load still in MEM.
    assign haz_mem = match_mem && mem_mem_read && !fwd_ex;

    always_comb begin
        sel = FWD_REG;
        if (fwd_ex) begin
            sel = FWD_EX;
        end else if (match_mem && !mem_mem_read) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/branch_operand_hazard_unit.sv
// ID-stage hazard/forwarding unit for early branch resolution over NUM_SRC
// operands. Optional stats outputs enabled by BRANCH_HAZARD_STATS_EN.
module branch_operand_hazard_unit
    import branch_operand_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = DEFAULT_REG_ADDR_W,
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned LOAD_STALL_EX  = 2,
    parameter int unsigned LOAD_STALL_MEM = 1,
    parameter int unsigned CNT_W          = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_branch,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          mem_reg_write,
    input  logic                          mem_mem_read,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          flush,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          bubble
`ifdef BRANCH_HAZARD_STATS_EN
   ,output logic [31:0]                   stat_stall_cycles,
    output logic [31:0]                   stat_fwd_events
`endif
);

    localparam logic [CNT_W-1:0] STALL_EX_N  = CNT_W'(LOAD_STALL_EX);
    localparam logic [CNT_W-1:0] STALL_MEM_N = CNT_W'(LOAD_STALL_MEM);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   need_n;
    logic               start;
    logic [NUM_SRC-1:0] haz_ex;
    logic [NUM_SRC-1:0] haz_mem;
    logic [1:0]         op_sel [NUM_SRC];

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_op
            operand_fwd_match #(
                .REG_ADDR_W(REG_ADDR_W)
            ) u_match (
                .enable       (id_branch),
                .src          (id_src[g*REG_ADDR_W +: REG_ADDR_W]),
                .ex_reg_write (ex_reg_write),
                .ex_mem_read  (ex_mem_read),
                .ex_rd        (ex_rd),
                .mem_reg_write(mem_reg_write),
                .mem_mem_read (mem_mem_read),
                .mem_rd       (mem_rd),
                .sel          (op_sel[g]),
                .haz_ex       (haz_ex[g]),
                .haz_mem      (haz_mem[g])
            );
        end
    endgenerate

    always_comb begin
        need_n = '0;
        if (|haz_ex) begin
            need_n = STALL_EX_N;
        end else if (|haz_mem) begin
            need_n = STALL_MEM_N;
        end
    end

    assign start  = (state == IDLE) && id_branch && (need_n != '0) && !flush;
    assign stall  = !rst && !flush && ((state == STALL) || start);
    assign bubble = stall;

    // Selects are only meaningful while idle; a stall in progress or a flush parks them at the regfile.
    always_comb begin
        fwd_sel = '0;
        if (!rst && !flush && (state == IDLE)) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                fwd_sel[i*2 +: 2] = op_sel[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                cnt   <= need_n - CNT_ONE;
                state <= (need_n > CNT_ONE) ? STALL : IDLE;
            end
        end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                state <= IDLE;
            end
        end
    end

`ifdef BRANCH_HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_fwd_events   <= '0;
        end else begin
            if (stall && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (id_branch && (fwd_sel != '0) && (stat_fwd_events != '1)) begin
                stat_fwd_events <= stat_fwd_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_operand_hazard_unit.sv
// Self-checking bench for branch_operand_hazard_unit: directed scenarios plus
// randomized traffic against a behavioural model (stats checked when enabled).
module tb_branch_operand_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_branch;
    logic [9:0] id_src;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_reg_write;
    logic       mem_mem_read;
    logic [4:0] mem_rd;
    logic       flush;
    logic [3:0] fwd_sel;
    logic       stall;
    logic       bubble;
`ifdef BRANCH_HAZARD_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_fwd_events;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_operand_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_branch    (id_branch),
        .id_src       (id_src),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .bubble       (bubble)
`ifdef BRANCH_HAZARD_STATS_EN
       ,.stat_stall_cycles(stat_stall_cycles),
        .stat_fwd_events  (stat_fwd_events)
`endif
    );

    task automatic drive(input logic b, input logic [4:0] s0, input logic [4:0] s1,
                         input logic exw, input logic exl, input logic [4:0] exrd,
                         input logic memw, input logic meml, input logic [4:0] memrd,
                         input logic fl);
        id_branch     = b;
        id_src        = {s1, s0};
        ex_reg_write  = exw;
        ex_mem_read   = exl;
        ex_rd         = exrd;
        mem_reg_write = memw;
        mem_mem_read  = meml;
        mem_rd        = memrd;
        flush         = fl;
    endtask

    // Next cycle: drive at the falling edge, sample 1 time unit later.
    task automatic cycle_drive(input logic b, input logic [4:0] s0, input logic [4:0] s1,
                               input logic exw, input logic exl, input logic [4:0] exrd,
                               input logic memw, input logic meml, input logic [4:0] memrd,
                               input logic fl);
        @(negedge clk);
        drive(b, s0, s1, exw, exl, exrd, memw, meml, memrd, fl);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5'd8, 5'd9, 1, 1, 5'd8, 1, 0, 5'd9, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b bubble=%b fwd_sel=%b required 0 0 0000", stall, bubble, fwd_sel);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: stall=%b fwd_sel=%b required 0 0000", stall, fwd_sel);
        end
    endtask

    task automatic test_ex_forward();
        apply_reset();
        cycle_drive(1, 5'd16, 5'd3, 1, 0, 5'd16, 0, 0, 5'd0, 0);
        checks++;
        if (fwd_sel !== 4'b0001 || stall !== 1'b0) begin
            errors++;
            $display("FAIL ex_forward: fwd_sel=%b stall=%b required 0001 0", fwd_sel, stall);
        end
        cycle_drive(0, 5'd16, 5'd3, 1, 0, 5'd16, 0, 0, 5'd0, 0);
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL no_branch_no_fwd: fwd_sel=%b required 0000", fwd_sel);
        end
`ifdef BRANCH_HAZARD_STATS_EN
        checks++;
        if (stat_fwd_events !== 32'd1) begin
            errors++;
            $display("FAIL stat_fwd_events: got %0d required 1", stat_fwd_events);
        end
`endif
    endtask

    task automatic test_priority_zero();
        apply_reset();
        cycle_drive(1, 5'd4, 5'd9, 1, 0, 5'd9, 1, 0, 5'd9, 0);
        checks++;
        if (fwd_sel !== 4'b0100) begin
            errors++;
            $display("FAIL ex_over_mem: fwd_sel=%b required 0100", fwd_sel);
        end
        cycle_drive(1, 5'd0, 5'd7, 1, 0, 5'd0, 0, 0, 5'd0, 0);
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL zero_reg: fwd_sel=%b required 0000", fwd_sel);
        end
        cycle_drive(1, 5'd5, 5'd7, 1, 0, 5'd12, 1, 0, 5'd5, 0);
        checks++;
        if (fwd_sel !== 4'b0010) begin
            errors++;
            $display("FAIL mem_forward: fwd_sel=%b required 0010", fwd_sel);
        end
    endtask

    task automatic test_load_ex();
        apply_reset();
        cycle_drive(1, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 5'd0, 0);
        checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL load_ex_c1: stall=%b bubble=%b fwd_sel=%b required 1 1 0000", stall, bubble, fwd_sel);
        end
        // Branch disappears mid-stall: the stall must still run its full length.
        cycle_drive(0, 5'd8, 5'd3, 0, 0, 5'd0, 1, 1, 5'd8, 0);
        checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL load_ex_c2: stall=%b bubble=%b fwd_sel=%b required 1 1 0000", stall, bubble, fwd_sel);
        end
        cycle_drive(1, 5'd8, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL load_ex_c3: stall=%b bubble=%b fwd_sel=%b required 0 0 0000", stall, bubble, fwd_sel);
        end
`ifdef BRANCH_HAZARD_STATS_EN
        checks++;
        if (stat_stall_cycles !== 32'd2) begin
            errors++;
            $display("FAIL stat_stall_cycles: got %0d required 2", stat_stall_cycles);
        end
`endif
    endtask

    task automatic test_load_mem();
        apply_reset();
        cycle_drive(1, 5'd1, 5'd8, 1, 0, 5'd20, 1, 1, 5'd8, 0);
        checks++;
        if (stall !== 1'b1 || bubble !== 1'b1) begin
            errors++;
            $display("FAIL load_mem_c1: stall=%b bubble=%b required 1 1", stall, bubble);
        end
        cycle_drive(1, 5'd1, 5'd8, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            errors++;
            $display("FAIL load_mem_c2: stall=%b bubble=%b required 0 0", stall, bubble);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        cycle_drive(1, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 5'd0, 0);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: stall=%b required 1", stall);
        end
        cycle_drive(1, 5'd8, 5'd3, 0, 0, 5'd0, 1, 1, 5'd8, 1);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL flush_in_stall: stall=%b bubble=%b fwd_sel=%b required 0 0 0000", stall, bubble, fwd_sel);
        end
        cycle_drive(1, 5'd8, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_after: stall=%b required 0", stall);
        end
        cycle_drive(1, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 5'd0, 1);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_hazard: stall=%b bubble=%b required 0 0", stall, bubble);
        end
        cycle_drive(1, 5'd8, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_hazard_after: stall=%b required 0", stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        cycle_drive(1, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 5'd0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_pre: stall=%b required 1", stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: stall=%b bubble=%b fwd_sel=%b required 0 0 0000", stall, bubble, fwd_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: stall=%b required 0", stall);
        end
    endtask

    // Behavioural reference: per-operand producer lookup and a count of owed stall cycles.
    task automatic test_random();
        int owed;
        int need;
        logic [3:0] exp_fwd;
        logic exp_stall;
        logic [4:0] s;
        logic mex, mmem, any_ex, any_mem;
        logic [1:0] code;
        apply_reset();
        owed = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0);
            #1;
            any_ex = 0;
            any_mem = 0;
            exp_fwd = '0;
            for (int i = 0; i < 2; i++) begin
                s = (i == 0) ? id_src[4:0] : id_src[9:5];
                mex  = id_branch && ex_reg_write && ex_rd != 0 && ex_rd == s;
                mmem = id_branch && mem_reg_write && mem_rd != 0 && mem_rd == s;
                code = 2'd0;
                if (mex && !ex_mem_read) code = 2'd1;
                else if (mmem && !mem_mem_read) code = 2'd2;
                if (mex && ex_mem_read) any_ex = 1;
                if (mmem && mem_mem_read && code != 2'd1) any_mem = 1;
                if (i == 0) exp_fwd[1:0] = code;
                else exp_fwd[3:2] = code;
            end
            need = any_ex ? 2 : (any_mem ? 1 : 0);
            if (flush) begin
                exp_stall = 0;
                exp_fwd = '0;
            end else if (owed > 0) begin
                exp_stall = 1;
                exp_fwd = '0;
            end else begin
                exp_stall = id_branch && need > 0;
            end
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL rand_stall cycle %0d: got %b required %b", c, stall, exp_stall);
            end
            checks++;
            if (bubble !== exp_stall) begin
                errors++;
                $display("FAIL rand_bubble cycle %0d: got %b required %b", c, bubble, exp_stall);
            end
            checks++;
            if (fwd_sel !== exp_fwd) begin
                errors++;
                $display("FAIL rand_fwd_sel cycle %0d: got %b required %b", c, fwd_sel, exp_fwd);
            end
            if (flush) owed = 0;
            else if (owed > 0) owed--;
            else if (exp_stall) owed = need - 1;
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority_zero();
        test_load_ex();
        test_load_mem();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
